mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-client scratch-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  // State encodings kept as plain constants for older code that compares raw bits
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker producing a one-hot grant.
// MEM_ARB_RR_EN defined: on contention, grant the requester that did not win last.
// MEM_ARB_RR_EN undefined: fixed priority, requester 0 wins on contention.
module mem_arb_pick (
  input  logic       valid0_i,
  input  logic       valid1_i,
`ifdef MEM_ARB_RR_EN
  input  logic       last_grant_i,
`endif
  output logic [1:0] grant_o
);

  // Pick at most one requester; a lone requester always wins
  always_comb begin
    // NOTE: a default before any branch keeps every path assigned, so no latch is inferred.
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
`ifdef MEM_ARB_RR_EN
      grant_o = last_grant_i ? 2'b01 : 2'b10;
`else
      grant_o = 2'b01;
`endif
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and access sequencer between two clients and the 16x8 synchronous-read
// scratch memory. One access at a time: IDLE (accept) -> ACCESS -> RESP -> IDLE,
// with the response pulse in the IDLE cycle after RESP.
// Optional feature: MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_adr,
  input  logic [DATA_W-1:0] req0_dat_w,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_adr,
  input  logic [DATA_W-1:0] req1_dat_w,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_dat_r,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_dat_r,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_dat_w,
  input  logic [DATA_W-1:0] mem_dat_r
);

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic              win_q, win_d;
  logic [1:0]        grant;
  logic              in_idle;
  logic              rsp_fire;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp0_valid_q, rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_dat_r_q, rsp1_dat_r_q;
`ifdef MEM_ARB_RR_EN
  logic              last_grant_q;
`endif

  assign in_idle = (state_q == IDLE);

  mem_arb_pick u_pick (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
`ifdef MEM_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .grant_o      (grant)
  );

  // Ready is only offered in IDLE and is forced low while reset is held
  assign req0_ready = rst_n & in_idle & grant[0];
  assign req1_ready = rst_n & in_idle & grant[1];

  // Memory port always reflects the latched request, so it holds its value in IDLE
  assign mem_adr   = req_q.adr;
  assign mem_dat_w = req_q.dat_w;
  assign mem_we    = (state_q == ACCESS) & req_q.we;

  // Response data: memory read data for reads, echo of the written data for writes
  assign rsp_fire = (state_q == RESP);
  assign rsp_data = req_q.we ? req_q.dat_w : mem_dat_r;

  // Next-state logic and request capture on acceptance
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = ACCESS;
          win_d   = grant[1];
          req_d   = grant[1] ? '{we: req1_we, adr: req1_adr, dat_w: req1_dat_w}
                             : '{we: req0_we, adr: req0_adr, dat_w: req0_dat_w};
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and latched request
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      win_q   <= win_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember the most recent winner; reset value lets requester 0 win first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (in_idle && (|grant)) begin
      last_grant_q <= grant[1];
    end
  end
`endif

  // One-cycle response pulse and held read data for the winning client
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_dat_r_q <= '0;
      rsp1_dat_r_q <= '0;
    end else begin
      rsp0_valid_q <= rsp_fire & ~win_q;
      rsp1_valid_q <= rsp_fire & win_q;
      if (rsp_fire && !win_q) rsp0_dat_r_q <= rsp_data;
      if (rsp_fire && win_q)  rsp1_dat_r_q <= rsp_data;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_dat_r = rsp0_dat_r_q;
  assign rsp1_dat_r = rsp1_dat_r_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 16x8 synchronous-read memory.
// Works in both builds; contention expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_we;
  logic [3:0] req0_adr;
  logic [7:0] req0_dat_w;
  logic       req1_valid, req1_ready, req1_we;
  logic [3:0] req1_adr;
  logic [7:0] req1_dat_w;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_dat_r, rsp1_dat_r;
  logic [3:0] mem_adr;
  logic       mem_we;
  logic [7:0] mem_dat_w;
  logic [7:0] mem_dat_r;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_adr   (req0_adr),
    .req0_dat_w (req0_dat_w),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_adr   (req1_adr),
    .req1_dat_w (req1_dat_w),
    .rsp0_valid (rsp0_valid),
    .rsp0_dat_r (rsp0_dat_r),
    .rsp1_valid (rsp1_valid),
    .rsp1_dat_r (rsp1_dat_r),
    .mem_adr    (mem_adr),
    .mem_we     (mem_we),
    .mem_dat_w  (mem_dat_w),
    .mem_dat_r  (mem_dat_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratch memory: word i starts at 0x10+i; read data is registered
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    mem_dat_r = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_adr] <= mem_dat_w;
    mem_dat_r <= mem[mem_adr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic v1, input logic we1, input logic [3:0] a1, input logic [7:0] d1);
    req0_valid = v0; req0_we = we0; req0_adr = a0; req0_dat_w = d0;
    req1_valid = v1; req1_we = we1; req1_adr = a1; req1_dat_w = d1;
  endtask

  typedef struct packed {
    logic       v0;
    logic       we0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic       we1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic       rdy0;
    logic       rdy1;
    logic       rsp0;
    logic       rsp1;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       mwe;
    logic [3:0] madr;
    logic [7:0] mdw;
  } vec_t;

  vec_t vecs [14];

`ifdef MEM_ARB_RR_EN
  // last_grant is 0 after the directed table (req0 won last)
  localparam logic [3:0] CONT_WIN = 4'b0101; // bit k = winner of k-th grant: 1,0,1,0
  localparam logic [1:0] PRE_RST_GRANT = 2'b10;
`else
  localparam logic [3:0] CONT_WIN = 4'b0000;
  localparam logic [1:0] PRE_RST_GRANT = 2'b01;
`endif

  initial begin
    // cycle-by-cycle directed table; row 0 is the first IDLE cycle after reset
    //         v0   we0  a0    d0      v1   we1  a1    d1      rdy0 rdy1 rsp0 rsp1 rd0     rd1     mwe  madr  mdw
    vecs[0]  = '{1'b1,1'b1,4'h3,8'hA5, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,4'h0,8'h00};
    vecs[1]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,4'h3,8'hA5};
    vecs[2]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,4'h3,8'hA5};
    vecs[3]  = '{1'b1,1'b0,4'h3,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b1,1'b0,8'hA5,8'h00,1'b0,4'h3,8'hA5};
    vecs[4]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'hA5,8'h00,1'b0,4'h3,8'h00};
    vecs[5]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'hA5,8'h00,1'b0,4'h3,8'h00};
    vecs[6]  = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'hF,8'h3C, 1'b0,1'b1,1'b1,1'b0,8'hA5,8'h00,1'b0,4'h3,8'h00};
    vecs[7]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'hA5,8'h00,1'b1,4'hF,8'h3C};
    vecs[8]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'hA5,8'h00,1'b0,4'hF,8'h3C};
    vecs[9]  = '{1'b1,1'b0,4'hF,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b0,1'b1,8'hA5,8'h3C,1'b0,4'hF,8'h3C};
    vecs[10] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'hA5,8'h3C,1'b0,4'hF,8'h00};
    vecs[11] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'hA5,8'h3C,1'b0,4'hF,8'h00};
    vecs[12] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b1,1'b0,8'h3C,8'h3C,1'b0,4'hF,8'h00};
    vecs[13] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h3C,8'h3C,1'b0,4'hF,8'h00};

    // ---- reset with both clients requesting writes ----
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 4'h7, 8'hEE, 1'b1, 1'b1, 4'h8, 8'hDD);
    repeat (2) @(negedge clk);
    #1;
    check("reset ready0", 32'(req0_ready), 32'd0);
    check("reset ready1", 32'(req1_ready), 32'd0);
    check("reset rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("reset rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_adr", 32'(mem_adr), 32'd0);
    check("reset mem_dat_w", 32'(mem_dat_w), 32'd0);
    check("reset rsp0_dat_r", 32'(rsp0_dat_r), 32'd0);
    check("reset rsp1_dat_r", 32'(rsp1_dat_r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);

    // ---- directed table: write/read by req0, cross-client write then read ----
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #1;
      check($sformatf("vec%0d ready0", i), 32'(req0_ready), 32'(vecs[i].rdy0));
      check($sformatf("vec%0d ready1", i), 32'(req1_ready), 32'(vecs[i].rdy1));
      check($sformatf("vec%0d rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].rsp0));
      check($sformatf("vec%0d rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].rsp1));
      check($sformatf("vec%0d rsp0_dat_r", i), 32'(rsp0_dat_r), 32'(vecs[i].rd0));
      check($sformatf("vec%0d rsp1_dat_r", i), 32'(rsp1_dat_r), 32'(vecs[i].rd1));
      check($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
      check($sformatf("vec%0d mem_adr", i), 32'(mem_adr), 32'(vecs[i].madr));
      check($sformatf("vec%0d mem_dat_w", i), 32'(mem_dat_w), 32'(vecs[i].mdw));
    end

    // ---- contention: both read continuously (req0 adr 5 -> 0x15, req1 adr 6 -> 0x16) ----
    for (int k = 0; k < 13; k++) begin
      logic idle, w, pw, busy;
      @(negedge clk);
      busy = (k < 12);
      drive(busy, 1'b0, 4'h5, 8'h00, busy, 1'b0, 4'h6, 8'h00);
      #1;
      idle = ((k % 3) == 0);
      w    = busy ? CONT_WIN[k / 3] : 1'b0;
      pw   = (k >= 3) ? CONT_WIN[k / 3 - 1] : 1'b0;
      check($sformatf("cont%0d ready0", k), 32'(req0_ready), 32'(idle && busy && !w));
      check($sformatf("cont%0d ready1", k), 32'(req1_ready), 32'(idle && busy && w));
      check($sformatf("cont%0d rsp0_valid", k), 32'(rsp0_valid), 32'(idle && (k >= 3) && !pw));
      check($sformatf("cont%0d rsp1_valid", k), 32'(rsp1_valid), 32'(idle && (k >= 3) && pw));
      if (idle && (k >= 3) && !pw) check($sformatf("cont%0d rsp0_dat_r", k), 32'(rsp0_dat_r), 32'h15);
      if (idle && (k >= 3) && pw)  check($sformatf("cont%0d rsp1_dat_r", k), 32'(rsp1_dat_r), 32'h16);
    end

    // ---- reset asserted mid-ACCESS of a write ----
    @(negedge clk);
    drive(1'b1, 1'b1, 4'h9, 8'h77, 1'b1, 1'b1, 4'hA, 8'h88);
    #1;
    check("pre-reset grant", 32'({req1_ready, req0_ready}), 32'(PRE_RST_GRANT));
    @(negedge clk);
    #1;
    check("pre-reset access mem_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-access reset mem_we", 32'(mem_we), 32'd0);
    check("mid-access reset ready0", 32'(req0_ready), 32'd0);
    check("mid-access reset ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    #1;
    check("in-reset rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("in-reset rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("in-reset mem_adr", 32'(mem_adr), 32'd0);
    check("in-reset rsp1_dat_r", 32'(rsp1_dat_r), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 1'b0, 4'h6, 8'h00);
    #1;
    check("post-reset ready0", 32'(req0_ready), 32'd1);
    check("post-reset ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    check("post-reset access rsp0_valid", 32'(rsp0_valid), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("post-reset rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("post-reset rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("post-reset rsp0_dat_r", 32'(rsp0_dat_r), 32'h15);
    @(negedge clk);
    #1;
    check("post-reset pulse ends", 32'(rsp0_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
